// File: rtl/pkt_dispatch_arb.sv
// pkt_dispatch_arb: round-robin dispatcher of a packet stream to one of N idle filter cores.
// Ports: clk, rst (async active-low); rdy_in[N] core idle flags; ack_out[N] one-cycle grant pulse;
// sel/sel_vld route beats to the owning core; pkt_valid/pkt_last/pkt_ready stream handshake;
// ovf pulses on an oversized packet; pkt_cnt counts delivered packets; ovf_cnt counts oversized ones.
module pkt_dispatch_arb #(
  parameter int N      = 4,
  parameter int TAG_SZ = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter int CNT_SZ = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      rdy_in,
  output logic [N-1:0]      ack_out,
  output logic [TAG_SZ-1:0] sel,
  output logic              sel_vld,
  input  logic              pkt_valid,
  input  logic              pkt_last,
  output logic              pkt_ready,
  output logic              ovf,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       ovf_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  // MAX_BEATS-1 = 2^CNT_SZ - 2
  localparam logic [CNT_SZ-1:0] LAST_CNT = ~CNT_SZ'(1);

  logic [1:0]        state_q, state_d;
  logic [TAG_SZ-1:0] ptr_q, ptr_d, sel_q, sel_d, win, nxt;
  logic [N-1:0]      ack_q, ack_d;
  logic              ovf_q, ovf_d;
  logic [CNT_SZ-1:0] beat_q, beat_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic [2*N-1:0]    rot;
  int                s;

  // Rotating so that bit 0 is the ptr position turns the wrap-around search into a plain priority pick.
  assign rot = {rdy_in, rdy_in} >> ptr_q;
  assign nxt = (sel_q == TAG_SZ'(N - 1)) ? '0 : sel_q + TAG_SZ'(1);

  // Descending scan so the lowest rotated offset is the last (winning) assignment.
  always_comb begin
    win = '0;
    s   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        s   = int'(ptr_q) + j;
        win = TAG_SZ'(s >= N ? s - N : s);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    ack_d     = '0;
    ovf_d     = 1'b0;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (state_q == IDLE) begin
      if (|rdy_in) begin
        state_d = XFER;
        sel_d   = win;
        ack_d   = N'(1) << win;
        beat_d  = '0;
      end
    end else if (pkt_valid) begin
      if (pkt_last) begin
        state_d   = IDLE;
        ptr_d     = nxt;
        beat_d    = '0;
        pkt_cnt_d = (state_q == XFER) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
      end else if (state_q == XFER) begin
        if (beat_q == LAST_CNT) begin
          state_d   = DRAIN;
          ovf_d     = 1'b1;
          beat_d    = '0;
          ovf_cnt_d = (&ovf_cnt_q) ? ovf_cnt_q : ovf_cnt_q + 16'd1;
        end else begin
          beat_d = beat_q + CNT_SZ'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      ack_q     <= '0;
      ovf_q     <= 1'b0;
      beat_q    <= '0;
      pkt_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      ovf_q     <= ovf_d;
      beat_q    <= beat_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ack_out   = ack_q;
  assign sel       = sel_q;
  assign sel_vld   = state_q == XFER;
  assign pkt_ready = state_q != IDLE;
  assign ovf       = ovf_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_pkt_dispatch_arb.sv
// tb_pkt_dispatch_arb: vector table, directed corner sequences and random stimulus against a reference model.
module tb_pkt_dispatch_arb;
  localparam int N    = 4;
  localparam int MAXB = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rdy;
  logic        pv, pl;
  logic [3:0]  ack;
  logic [1:0]  sel;
  logic        vld, rdyo, ovf;
  logic [31:0] pc;
  logic [15:0] oc;

  logic [2:0]  rdy3, ack3;
  logic [1:0]  sel3;
  logic        vld3, rdyo3, ovf3;
  logic [31:0] pc3;
  logic [15:0] oc3;

  pkt_dispatch_arb #(.N(4), .CNT_SZ(3)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy), .ack_out(ack), .sel(sel), .sel_vld(vld),
    .pkt_valid(pv), .pkt_last(pl), .pkt_ready(rdyo), .ovf(ovf), .pkt_cnt(pc), .ovf_cnt(oc)
  );

  pkt_dispatch_arb #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .rdy_in(rdy3), .ack_out(ack3), .sel(sel3), .sel_vld(vld3),
    .pkt_valid(pv), .pkt_last(pl), .pkt_ready(rdyo3), .ovf(ovf3), .pkt_cnt(pc3), .ovf_cnt(oc3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner/busy/draining view of the dispatcher, advanced once per clock edge.
  int          m_busy, m_drain, m_sel, m_ptr, m_beats, m_ack, m_ovf, m_oc;
  logic [31:0] m_pc;

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
    m_ack = 0; m_ovf = 0; m_oc = 0; m_pc = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic v, input logic l);
    int k;
    m_ack = 0;
    m_ovf = 0;
    if (!m_busy) begin
      if (r != 0) begin
        k = 0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (r[k]) break;
        end
        m_sel = k; m_ack = 1 << k; m_busy = 1; m_drain = 0; m_beats = 0;
      end
    end else if (v) begin
      if (l) begin
        if (!m_drain) m_pc = m_pc + 1;
        m_busy = 0; m_ptr = (m_sel + 1) % N; m_beats = 0;
      end else if (!m_drain) begin
        if (m_beats == MAXB - 1) begin
          m_ovf = 1; m_drain = 1; m_beats = 0;
          if (m_oc < 65535) m_oc++;
        end else m_beats++;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic v, input logic l);
    rdy = r; pv = v; pl = l;
    @(posedge clk);
    model_edge(r, v, l);
    #1;
    chk("ack_out", ack, m_ack);
    chk("sel", sel, m_sel);
    chk("sel_vld", vld, m_busy && !m_drain);
    chk("pkt_ready", rdyo, m_busy != 0);
    chk("ovf", ovf, m_ovf);
    chk("pkt_cnt", pc, m_pc);
    chk("ovf_cnt", oc, m_oc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ack"}, ack, 0);
    chk({tag, " sel"}, sel, 0);
    chk({tag, " sel_vld"}, vld, 0);
    chk({tag, " pkt_ready"}, rdyo, 0);
    chk({tag, " ovf"}, ovf, 0);
    chk({tag, " pkt_cnt"}, pc, 0);
    chk({tag, " ovf_cnt"}, oc, 0);
    chk({tag, " n3 ack"}, ack3, 0);
    chk({tag, " n3 ready"}, rdyo3, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = '0; pv = 1'b0; pl = 1'b0; rdy3 = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [3:0] r;
    logic       v, l;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       vld, rdy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[1] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[2] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[3] = '{4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1};
    tbl[4] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[5] = '{4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[6] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[7] = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[8] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};

    do_reset();
    for (int t = 0; t < 9; t++) begin
      step(tbl[t].r, tbl[t].v, tbl[t].l);
      chk($sformatf("tbl%0d ack", t), ack, tbl[t].ack);
      chk($sformatf("tbl%0d sel", t), sel, tbl[t].sel);
      chk($sformatf("tbl%0d sel_vld", t), vld, tbl[t].vld);
      chk($sformatf("tbl%0d pkt_ready", t), rdyo, tbl[t].rdy);
    end
    chk("tbl pkt_cnt", pc, 4);

    do_reset();
    for (int p = 0; p < 4; p++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("rr sel", sel, p);
      chk("rr ack", ack, 4'b0001 << p);
      step(4'b1111, 1'b1, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
      step(4'b1111, 1'b1, 1'b1);
    end
    chk("rr pkt_cnt", pc, 4);

    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(4'b0000, 1'b1, i == 8);
      if (i == 6) begin
        chk("ovf pulse", ovf, 1);
        chk("ovf drain sel_vld", vld, 0);
        chk("ovf drain ready", rdyo, 1);
      end
      if (i == 7) chk("ovf one cycle", ovf, 0);
    end
    chk("ovf ovf_cnt", oc, 1);
    chk("ovf pkt_cnt", pc, 0);
    chk("ovf back to idle", rdyo, 0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b1, 1'($urandom % 2));
      chk("norq ready", rdyo, 0);
      chk("norq ack", ack, 0);
    end
    step(4'b0100, 1'b0, 1'b0);
    chk("late req ack", ack, 4'b0100);

    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    pv = 1'b1; pl = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("midpkt");
    @(posedge clk);
    #1;
    chk_reset_vals("midpkt hold");
    @(negedge clk);
    rst = 1'b1;
    step(4'b0110, 1'b0, 1'b0);
    chk("post reset grant", ack, 4'b0010);
    chk("post reset sel", sel, 1);

    do_reset();
    rdy3 = 3'b111;
    for (int p = 0; p < 4; p++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk("n3 sel", sel3, p % 3);
      chk("n3 ack", ack3, 3'b001 << (p % 3));
      step(4'b0000, 1'b1, 1'b1);
      chk("n3 sel range", sel3 < 2'd3, 1);
    end
    chk("n3 pkt_cnt", pc3, 4);

    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step(($urandom % 4 == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
           1'($urandom % 4 != 0), 1'($urandom % 5 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
